// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared constants, state encoding and helpers for the 5x5 window generator
package conv_pkg;

    localparam int K          = 5;
    localparam int N_LB       = K - 1;
    localparam int DEF_IMG_W  = 32;
    localparam int DEF_IMG_H  = 32;
    localparam int DEF_DATA_W = 8;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_FILL = 2'd1;
    localparam state_t S_RUN  = 2'd2;

    // Counter width that never collapses to zero bits for tiny ranges.
    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Byte position of window tap (r, c) inside win_out: row-major, top-left first.
    function automatic int win_byte(input int r, input int c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/conv_window_5x5_if.sv
// rtl/conv_window_5x5_if.sv - pixel stream in, window stream out for conv_window_5x5
interface conv_window_5x5_if
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int ROW_W = width_of(IMG_H - K + 1);
    localparam int COL_W = width_of(IMG_W - K + 1);

    logic                    frame_clr;
    logic                    valid_in;
    logic [DATA_W-1:0]       pix_in;
    logic                    valid_out;
    logic [K*K*DATA_W-1:0]   win_out;
    logic [ROW_W-1:0]        out_row;
    logic [COL_W-1:0]        out_col;
    logic                    frame_done;
    logic                    busy;

    modport master (
        output frame_clr, valid_in, pix_in,
        input  valid_out, win_out, out_row, out_col, frame_done, busy
    );

    modport slave (
        input  frame_clr, valid_in, pix_in,
        output valid_out, win_out, out_row, out_col, frame_done, busy
    );

endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one image row of pixels, read-before-write at a single address
module line_buffer
    import conv_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_W,
    parameter int DATA_W = DEF_DATA_W,
    localparam int AW    = width_of(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read is combinational so the old word is seen in the same cycle it is replaced.
    assign rd_data = mem[addr];

    // Contents are never cleared; every position is rewritten before it is used.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_5x5.sv
// rtl/conv_window_5x5.sv - streaming 5x5 window generator feeding the convolution PE
module conv_window_5x5
    import conv_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    conv_window_5x5_if.slave  bus
);

    localparam int CW  = width_of(IMG_W);
    localparam int RW  = width_of(IMG_H);
    localparam int ORW = width_of(IMG_H - K + 1);
    localparam int OCW = width_of(IMG_W - K + 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    state_t        state;

    logic          accept;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [CW-1:0] nxt_col;
    logic [RW-1:0] nxt_row;
    logic          last_pix;
    logic          win_pos;

    logic [N_LB-1:0][DATA_W-1:0] lb_rd;
    logic [N_LB-1:0][DATA_W-1:0] lb_wr;
    logic [K-1:0][DATA_W-1:0]    new_col;
    logic [K-1:0][K-1:0][DATA_W-1:0] win;

    // A frame_clr with a pixel in the same cycle makes that pixel (0,0) of the new frame.
    assign accept   = bus.valid_in;
    assign cur_col  = bus.frame_clr ? '0 : col;
    assign cur_row  = bus.frame_clr ? '0 : row;
    assign last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));
    assign win_pos  = (cur_row >= RW'(K - 1)) && (cur_col >= CW'(K - 1));

    // Raster coordinate of the pixel after the current one.
    always_comb begin
        nxt_col = cur_col + CW'(1);
        nxt_row = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            nxt_col = '0;
            nxt_row = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
        end
    end

    // Line buffers form a vertical shift chain: each one takes the row the next one held.
    for (genvar i = 0; i < N_LB; i++) begin : g_lb
        if (i == N_LB - 1) begin : g_newest
            assign lb_wr[i] = bus.pix_in;
        end else begin : g_older
            assign lb_wr[i] = lb_rd[i+1];
        end
        line_buffer #(
            .DEPTH  (IMG_W),
            .DATA_W (DATA_W)
        ) u_lb (
            .clk     (clk),
            .we      (accept),
            .addr    (cur_col),
            .wr_data (lb_wr[i]),
            .rd_data (lb_rd[i])
        );
    end

    // Incoming window column, oldest row on top.
    always_comb begin
        new_col = '0;
        for (int r = 0; r < N_LB; r++) begin
            new_col[r] = lb_rd[r];
        end
        new_col[K-1] = bus.pix_in;
    end

    // Window slides one column left per accepted pixel and takes the new column on the right.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win <= '0;
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    win[r][c] <= win[r][c+1];
                end
                win[r][K-1] <= new_col[r];
            end
        end
    end

    // Flatten the window into the PE byte order.
    always_comb begin
        bus.win_out = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                bus.win_out[win_byte(r, c)*DATA_W +: DATA_W] = win[r][c];
            end
        end
    end

    // Coordinate counters and frame-phase FSM; frame_clr alone just rewinds to idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            col   <= '0;
            row   <= '0;
            state <= S_IDLE;
        end else if (accept) begin
            col <= nxt_col;
            row <= nxt_row;
            if (last_pix) begin
                state <= S_IDLE;
            end else if (nxt_row >= RW'(K - 1)) begin
                state <= S_RUN;
            end else begin
                state <= S_FILL;
            end
        end else if (bus.frame_clr) begin
            col   <= '0;
            row   <= '0;
            state <= S_IDLE;
        end
    end

    assign bus.busy = (state != S_IDLE);

    // Registered window strobe, output-map coordinate and end-of-frame pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.valid_out  <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.out_row    <= '0;
            bus.out_col    <= '0;
        end else begin
            bus.valid_out  <= accept && win_pos;
            bus.frame_done <= accept && last_pix;
            if (accept && win_pos) begin
                bus.out_row <= ORW'(cur_row - RW'(K - 1));
                bus.out_col <= OCW'(cur_col - CW'(K - 1));
            end
        end
    end

endmodule

// File: tb/tb_conv_window_5x5.sv
// tb/tb_conv_window_5x5.sv - self-checking bench for conv_window_5x5
module tb_conv_window_5x5;
    import conv_pkg::*;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int DW = 8;
    localparam int NB = K * K * DW;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    conv_window_5x5_if #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) bus ();

    conv_window_5x5 #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    // Model: the image as written so far, plus the expected outputs after each edge.
    logic [DW-1:0] img [H][W];
    int            m_row, m_col, acc_cnt;
    logic          exp_valid, exp_done, exp_busy;
    logic [NB-1:0] exp_win, last_win;
    int            exp_r, exp_c;

    // Observations from the compare process.
    int            vcnt, dcnt, first_acc, first_r, first_c, done_r, done_c;
    bit            seen;
    logic [NB-1:0] first_win, done_win;

    task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] byte_of(input logic [NB-1:0] w, input int k);
        return w[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] pix_a(input int r, input int c);
        return DW'((r * W + c) % 256);
    endfunction

    task automatic model_step(input bit v, input logic [DW-1:0] p, input bit clr);
        if (clr) begin
            m_row = 0; m_col = 0; acc_cnt = 0; exp_busy = 1'b0;
        end
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (v) begin
            img[m_row][m_col] = p;
            acc_cnt++;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                exp_valid = 1'b1;
                exp_r = m_row - (K - 1);
                exp_c = m_col - (K - 1);
                for (int k = 0; k < K * K; k++) begin
                    exp_win[k*DW +: DW] = img[exp_r + k / K][exp_c + k % K];
                end
                last_win = exp_win;
            end
            if (m_row == H - 1 && m_col == W - 1) begin
                exp_done = 1'b1; exp_busy = 1'b0;
                m_row = 0; m_col = 0; acc_cnt = 0;
            end else begin
                exp_busy = 1'b1;
                m_col++;
                if (m_col == W) begin
                    m_col = 0; m_row++;
                end
            end
        end
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] p, input bit clr);
        @(negedge clk);
        bus.valid_in  = v;
        bus.pix_in    = p;
        bus.frame_clr = clr;
        @(posedge clk);
        #1;
        model_step(v, p, clr);
        bus.valid_in  = 1'b0;
        bus.frame_clr = 1'b0;
    endtask

    task automatic run_frame(input bit inv, input bit gaps, input int start_idx, input int n);
        logic [DW-1:0] p;
        for (int i = start_idx; i < start_idx + n; i++) begin
            p = pix_a(i / W, i % W);
            if (inv) p = ~p;
            drive(1'b1, p, 1'b0);
            if (gaps) repeat ($urandom_range(0, 2)) drive(1'b0, '0, 1'b0);
        end
    endtask

    task automatic clear_obs();
        vcnt = 0; dcnt = 0; seen = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid_out"},  NB'(bus.valid_out), '0);
        check({tag, "_frame_done"}, NB'(bus.frame_done), '0);
        check({tag, "_busy"},       NB'(bus.busy), '0);
        check({tag, "_win_out"},    bus.win_out, '0);
        check({tag, "_out_row"},    NB'(bus.out_row), '0);
        check({tag, "_out_col"},    NB'(bus.out_col), '0);
    endtask

    // Compare process: DUT against model on every cycle, window data whenever it is valid.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_int("valid_out", int'(bus.valid_out), int'(exp_valid));
                check_int("frame_done", int'(bus.frame_done), int'(exp_done));
                check_int("busy", int'(bus.busy), int'(exp_busy));
                if (exp_valid && bus.valid_out) begin
                    check("win_out", bus.win_out, exp_win);
                    check_int("out_row", int'(bus.out_row), exp_r);
                    check_int("out_col", int'(bus.out_col), exp_c);
                end
                if (bus.valid_out) begin
                    vcnt++;
                    if (!seen) begin
                        seen      = 1'b1;
                        first_win = bus.win_out;
                        first_r   = int'(bus.out_row);
                        first_c   = int'(bus.out_col);
                        first_acc = acc_cnt;
                    end
                end
                if (bus.frame_done) begin
                    dcnt++;
                    done_win = bus.win_out;
                    done_r   = int'(bus.out_row);
                    done_c   = int'(bus.out_col);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
        $fatal(1);
    end

    initial begin
        bus.valid_in = 1'b0; bus.pix_in = '0; bus.frame_clr = 1'b0;
        m_row = 0; m_col = 0; acc_cnt = 0; exp_r = 0; exp_c = 0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
        exp_win = '0; last_win = '0; first_win = '0; done_win = '0;
        first_acc = 0; first_r = 0; first_c = 0; done_r = 0; done_c = 0;
        clear_obs();

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Continuous frame
        clear_obs();
        run_frame(1'b0, 1'b0, 0, W * H);
        repeat (3) drive(1'b0, '0, 1'b0);
        check_int("a_first_acc", first_acc, 133);
        check_int("a_first_byte0", int'(byte_of(first_win, 0)), 0);
        check_int("a_first_byte12", int'(byte_of(first_win, 12)), 66);
        check_int("a_first_byte24", int'(byte_of(first_win, 24)), 132);
        check_int("a_first_row", first_r, 0);
        check_int("a_first_col", first_c, 0);
        check_int("a_windows", vcnt, 784);
        check_int("a_done_count", dcnt, 1);
        check_int("a_done_row", done_r, 27);
        check_int("a_done_col", done_c, 27);
        check_int("a_done_byte24", int'(byte_of(done_win, 24)), 255);
        check("a_idle_hold", bus.win_out, last_win);

        // Same frame with random idle gaps
        clear_obs();
        run_frame(1'b0, 1'b1, 0, W * H);
        repeat (3) drive(1'b0, '0, 1'b0);
        check_int("gap_first_acc", first_acc, 133);
        check_int("gap_first_byte12", int'(byte_of(first_win, 12)), 66);
        check_int("gap_windows", vcnt, 784);
        check_int("gap_done_count", dcnt, 1);
        check_int("gap_done_byte24", int'(byte_of(done_win, 24)), 255);

        // Back-to-back frames, second one inverted
        clear_obs();
        run_frame(1'b0, 1'b0, 0, W * H);
        run_frame(1'b1, 1'b0, 0, W * H);
        repeat (2) drive(1'b0, '0, 1'b0);
        check_int("b2b_done_count", dcnt, 2);
        check_int("b2b_windows", vcnt, 1568);
        check_int("b2b_done_byte24", int'(byte_of(done_win, 24)), 0);
        check_int("b2b_done_byte0", int'(byte_of(done_win, 0)), 132);

        // Abort with frame_clr after 500 pixels, then a full frame
        clear_obs();
        run_frame(1'b0, 1'b0, 0, 500);
        check_int("abort_done_count", dcnt, 0);
        drive(1'b0, '0, 1'b1);
        clear_obs();
        run_frame(1'b0, 1'b0, 0, W * H);
        repeat (2) drive(1'b0, '0, 1'b0);
        check_int("clr_first_acc", first_acc, 133);
        check_int("clr_first_byte0", int'(byte_of(first_win, 0)), 0);
        check_int("clr_windows", vcnt, 784);
        check_int("clr_done_count", dcnt, 1);

        // frame_clr coincident with a pixel: that pixel is (0,0)
        run_frame(1'b0, 1'b0, 0, 100);
        clear_obs();
        drive(1'b1, 8'hAA, 1'b1);
        run_frame(1'b0, 1'b0, 1, W * H - 1);
        repeat (2) drive(1'b0, '0, 1'b0);
        check_int("clrv_first_byte0", int'(byte_of(first_win, 0)), 8'hAA);
        check_int("clrv_first_acc", first_acc, 133);
        check_int("clrv_windows", vcnt, 784);
        check_int("clrv_done_count", dcnt, 1);

        // Asynchronous reset mid-frame, then a full frame
        clear_obs();
        run_frame(1'b0, 1'b0, 0, 300);
        #2;
        reset_n = 1'b0;
        exp_valid = 1'b0; exp_done = 1'b0; exp_busy = 1'b0;
        m_row = 0; m_col = 0; acc_cnt = 0;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        clear_obs();
        run_frame(1'b0, 1'b0, 0, W * H);
        repeat (2) drive(1'b0, '0, 1'b0);
        check_int("rst_first_acc", first_acc, 133);
        check_int("rst_first_byte12", int'(byte_of(first_win, 12)), 66);
        check_int("rst_windows", vcnt, 784);
        check_int("rst_done_count", dcnt, 1);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_window_5x5.md
# conv_window_5x5

Streaming 5x5 window generator that sits directly upstream of the 5x5 convolution PE. It accepts one raster-scan 8-bit unsigned pixel per cycle and keeps the previous four image rows in line buffers. For every stride-1 "valid" convolution position it presents the complete 25-pixel window, with a valid strobe, in the PE's row-major input order. It also reports the output coordinate and pulses an end-of-frame flag.

## Interface
- IMG_W, 32, image width in pixels (≥ 5)
- IMG_H, 32, image height in pixels (≥ 5)
- DATA_W, 8, pixel width (unsigned)
- clk  input  1  rising-edge clock, single clock domain
- reset_n  input  1  asynchronous, active-low reset
- frame_clr  input  1  synchronous pulse: restart frame at pixel (0,0)
- valid_in  input  1  pix_in is valid; accepted on every cycle it is high (no backpressure)
- pix_in  input  DATA_W  pixel, raster order (row-major, col 0 first)
- valid_out  output  1  win_out / out_row / out_col valid this cycle
- win_out  output  25*DATA_W  window; byte k = row k/5, col k%5; byte 0 = top-left (oldest), byte 24 = bottom-right (newest); byte k drives PE in_IF(k+1)
- out_row  output  $clog2(IMG_H-4)  output-map row of current window
- out_col  output  $clog2(IMG_W-4)  output-map column of current window
- frame_done  output  1  one-cycle pulse coincident with the last valid_out of a frame
- busy  output  1  high from first accepted pixel until frame_done

## Operation
- Input coordinate counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on accepted pixels. col wraps to 0 and increments row; after (IMG_H-1, IMG_W-1) both wrap to 0.
- Four line buffers LB0..LB3, each IMG_W deep, addressed by col. On accept:
  - read all four buffers at col;
  - write LB0←LB1[col], LB1←LB2[col], LB2←LB3[col], LB3←pix_in (read-before-write at the same address).
- Window register 5x5: on accept, every row shifts one column left, and the new column 4 is loaded top to bottom with {LB0[col], LB1[col], LB2[col], LB3[col], pix_in}.
- FSM states:
  - S_IDLE: no pixel yet → S_FILL on the first accept.
  - S_FILL: row < 4 → S_RUN when row reaches 4.
  - S_RUN: row ≥ 4 → S_IDLE after the accept of the last pixel.
- valid_out goes high in the cycle after an accepted pixel with row ≥ 4 and col ≥ 4. out_row = row−4 and out_col = col−4 of that pixel.
- Window count per frame is exactly (IMG_W−4)*(IMG_H−4), which is 784 for 32x32.
- Line-buffer and window contents are not cleared at frame start. Stale data never appears under valid_out, because every valid window is fully overwritten by the current frame.
- frame_clr: the FSM goes to S_IDLE and the counters are zeroed.
  - If valid_in is high in the same cycle, that pixel is accepted as (0,0) of the new frame and the FSM enters S_FILL.
  - A frame_clr never produces frame_done.

## Timing
- Latency: 1 cycle from accepting the window-completing pixel to valid_out. Throughput is 1 window per cycle.
- valid_out, frame_done and busy-clear are registered.
- Idle cycles (valid_in low) freeze counters, FSM, buffers and window. valid_out is low on those cycles, and win_out holds its last value.
- At reset: valid_out=0, frame_done=0, busy=0, win_out=0, out_row=0, out_col=0, FSM=S_IDLE, counters=0.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is issued, and the next accepted pixel is (0,0).

## Structure
- Shared package conv_pkg holds:
  - K=5;
  - default IMG_W/IMG_H=32;
  - DATA_W=8;
  - the FSM state enum {S_IDLE, S_FILL, S_RUN};
  - the byte-index helper constant for win_out ordering.
- Sub-module line_buffer: a single-port-per-cycle read-before-write array, depth IMG_W, width DATA_W, instantiated 4×. The window register, counters and FSM live in conv_window_5x5.

## Test plan
- Frame of 32x32 with pix = (row*32+col) mod 256, valid_in always high:
  - first valid_out is one cycle after pixel index 132, with byte0=0, byte12=66, byte24=132, out_row=0, out_col=0;
  - exactly 784 valid_out pulses;
  - frame_done coincides with out_row=27, out_col=27, byte24=255.
- Same frame with valid_in toggled 1-0-0 pseudo-randomly: identical window sequence, and valid_out never asserts on a cycle not following an accept.
- Two back-to-back frames (second frame pix = 255 − first): second frame's windows contain only second-frame values, and frame_done pulses exactly twice.
- frame_clr after 500 pixels, followed by a full frame: no frame_done for the aborted frame; 784 correct windows; first window again after 133 accepts.
- frame_clr together with valid_in, pix=0xAA: that pixel becomes (0,0), so byte0 of the first window = 0xAA.
- reset_n pulsed low mid-frame (asynchronously, between clock edges): all outputs are 0 immediately, and a following full frame is correct.
